// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry output holding register.
//
// Ports
//   clk        in   sole clock, all state on the rising edge
//   reset      in   asynchronous, active-low reset
//   rx_pin     in   serial line (asynchronous to clk, idle high, LSB first)
//   data[7:0]  out  last accepted byte
//   valid      out  data holds a byte the consumer has not yet acknowledged
//   ack        in   consumer takes data when high together with valid
//   frame_err  out  one-cycle pulse when a stop bit is sampled low
//   overrun    out  sticky; a complete byte was dropped because valid was held
//   busy       out  receiver is anywhere other than IDLE
//
// Parameters
//   CLOCK_RATE  clk frequency in Hz
//   BAUD_RATE   serial bit rate; CLOCK_RATE/BAUD_RATE must be an integer >= 4
module uart_rx #(
  parameter int CLOCK_RATE = 1000,
  parameter int BAUD_RATE  = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Bit timing relies on an exact whole number of clocks per bit and at
  // least a few clocks to place the mid-bit sample.
  if (((CLOCK_RATE % BAUD_RATE) != 0) || (CLKS_PER_BIT < 4)) begin : g_bad_rate
    $error("uart_rx: CLOCK_RATE/BAUD_RATE must be an integer >= 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state_q,     state_d;
  logic             sync1_q,     sync1_d;
  logic             sync2_q,     sync2_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;
  logic             deliver;
  logic             rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    sync1_d     = rx_pin;
    sync2_d     = sync1_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    deliver     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_ZERO;
        end
      end

      // Sample half a bit in; a line that is high again was only a glitch.
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = CNT_ZERO;
          bit_idx_d = 3'd0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // From mid-start, one full bit period lands in the middle of each bit.
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = CNT_ZERO;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = CNT_ZERO;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A low line after a bad stop bit is a break; wait it out before
      // looking for the next start bit.
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Holding register: a same-cycle ack frees the slot for the new byte.
    if (deliver) begin
      if (!valid_q || ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLOCK_RATE=1000,
// BAUD_RATE=125 (8 clocks per bit). Frames are driven bit by bit on rx_pin;
// expected data/valid/overrun come from a small holding-register model.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk;
  logic       reset;
  logic       rx_pin;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int passed = 0;
  int total  = 0;

  // Per-frame observation, counted in clock edges since the start bit began.
  int   cyc;
  int   rise_cyc;
  int   ferr_cnt;
  int   ack_at;
  logic prev_valid;
  logic busy_seen;

  // Reference model of the consumer-visible holding register.
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_overrun;

  uart_rx #(
    .CLOCK_RATE(1000),
    .BAUD_RATE (125)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_pin   (rx_pin),
    .data     (data),
    .valid    (valid),
    .ack      (ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    ack = (ack_at == cyc + 1);
    @(posedge clk);
    #1;
    cyc++;
    if (valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    if (frame_err) ferr_cnt++;
    if (busy) busy_seen = 1'b1;
    prev_valid = valid;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    cyc        = 0;
    rise_cyc   = -1;
    ferr_cnt   = 0;
    prev_valid = valid;
    rx_pin = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CPB) tick();
    end
    rx_pin = stop;
    repeat (CPB) tick();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", frame_err); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1);
    total++; if (rise_cyc < 78 || rise_cyc > 80) $display("FAIL single_latency got=%0d exp=79+/-1", rise_cyc); else passed++;
    total++; if (data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", data); else passed++;
    total++; if (valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", valid); else passed++;
    total++; if (ferr_cnt !== 0) $display("FAIL single_frame_err got=%0d exp=0", ferr_cnt); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL single_overrun got=%b exp=0", overrun); else passed++;
    pulse_ack();
    total++; if (valid !== 1'b0) $display("FAIL single_ack_valid got=%b exp=0", valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_glitch();
    logic flag_seen;
    flag_seen = 1'b0;
    busy_seen = 1'b0;
    cyc = 0;
    rx_pin = 1'b0;
    repeat (2) tick();
    rx_pin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid || frame_err || overrun) flag_seen = 1'b1;
    end
    total++; if (busy_seen !== 1'b1) $display("FAIL glitch_busy_seen got=%b exp=1", busy_seen); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy_end got=%b exp=0", busy); else passed++;
    total++; if (flag_seen !== 1'b0) $display("FAIL glitch_flags got=%b exp=0", flag_seen); else passed++;
  endtask

  task automatic test_break();
    int not_busy;
    send_frame(8'h3C, 1'b0);
    total++; if (ferr_cnt !== 1) $display("FAIL break_frame_err_pulses got=%0d exp=1", ferr_cnt); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL break_valid got=%b exp=0", valid); else passed++;
    not_busy = 0;
    ferr_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) not_busy++;
    end
    total++; if (not_busy !== 0) $display("FAIL break_hold_busy idle_cycles=%0d exp=0", not_busy); else passed++;
    rx_pin = 1'b1;
    repeat (80) tick();
    total++; if (ferr_cnt !== 0) $display("FAIL break_no_new_frame_err got=%0d exp=0", ferr_cnt); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL break_no_bogus_byte got=%b exp=0", valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL break_idle_after got=%b exp=0", busy); else passed++;
    send_frame(8'h81, 1'b1);
    total++; if (data !== 8'h81) $display("FAIL break_next_data got=%h exp=81", data); else passed++;
    total++; if (valid !== 1'b1) $display("FAIL break_next_valid got=%b exp=1", valid); else passed++;
    pulse_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    total++; if (data !== 8'h11) $display("FAIL overrun_data got=%h exp=11", data); else passed++;
    total++; if (valid !== 1'b1) $display("FAIL overrun_valid got=%b exp=1", valid); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL overrun_flag got=%b exp=1", overrun); else passed++;
    pulse_ack();
    total++; if (valid !== 1'b0) $display("FAIL overrun_ack_valid got=%b exp=0", valid); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL overrun_ack_flag got=%b exp=0", overrun); else passed++;
    total++; if (data !== 8'h11) $display("FAIL overrun_ack_data got=%h exp=11", data); else passed++;
  endtask

  task automatic test_ack_in_delivery();
    send_frame(8'h11, 1'b1);
    ack_at = 79;
    send_frame(8'h22, 1'b1);
    ack_at = -1;
    total++; if (data !== 8'h22) $display("FAIL ackdel_data got=%h exp=22", data); else passed++;
    total++; if (valid !== 1'b1) $display("FAIL ackdel_valid got=%b exp=1", valid); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL ackdel_overrun got=%b exp=0", overrun); else passed++;
    pulse_ack();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    int         mode;
    logic       expect_rise;
    m_data    = data;
    m_valid   = valid;
    m_overrun = overrun;
    for (int n = 0; n < 20; n++) begin
      b    = 8'($urandom);
      stop = (($urandom % 5) != 0);
      mode = stop ? int'($urandom % 3) : 0;
      expect_rise = stop && !m_valid;
      ack_at = (mode == 1) ? 79 : -1;
      send_frame(b, stop);
      ack_at = -1;
      if (stop) begin
        if (!m_valid || mode == 1) begin
          m_data  = b;
          m_valid = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
      end else begin
        repeat ($urandom_range(0, 20)) tick();
        rx_pin = 1'b1;
        repeat (4) tick();
      end
      total++; if (ferr_cnt !== (stop ? 0 : 1)) $display("FAIL rand%0d_frame_err got=%0d exp=%0d", n, ferr_cnt, stop ? 0 : 1); else passed++;
      total++; if (data !== m_data) $display("FAIL rand%0d_data got=%h exp=%h", n, data, m_data); else passed++;
      total++; if (valid !== m_valid) $display("FAIL rand%0d_valid got=%b exp=%b", n, valid, m_valid); else passed++;
      total++; if (overrun !== m_overrun) $display("FAIL rand%0d_overrun got=%b exp=%b", n, overrun, m_overrun); else passed++;
      if (expect_rise) begin
        total++; if (rise_cyc < 78 || rise_cyc > 80) $display("FAIL rand%0d_latency got=%0d exp=79+/-1", n, rise_cyc); else passed++;
      end else begin
        total++; if (rise_cyc !== -1) $display("FAIL rand%0d_no_rise got=%0d exp=-1", n, rise_cyc); else passed++;
      end
      if (mode == 2) begin
        pulse_ack();
        if (m_valid) begin
          m_valid   = 1'b0;
          m_overrun = 1'b0;
        end
        total++; if (valid !== m_valid || overrun !== m_overrun) $display("FAIL rand%0d_ack got=%b%b exp=%b%b", n, valid, overrun, m_valid, m_overrun); else passed++;
      end
      rx_pin = 1'b1;
      repeat ($urandom_range(0, 5)) tick();
    end
    if (valid) pulse_ack();
  endtask

  task automatic test_reset_mid();
    logic [7:0] first;
    logic [7:0] partial;
    first   = 8'(($urandom % 255) + 1);
    partial = 8'($urandom);
    send_frame(first, 1'b1);
    total++; if (data !== first || valid !== 1'b1) $display("FAIL rstmid_pre got=%h/%b exp=%h/1", data, valid, first); else passed++;
    rx_pin = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx_pin = partial[i];
      repeat (CPB) tick();
    end
    rx_pin = partial[4];
    repeat (CPB / 2) tick();
    #2;
    reset = 1'b0;
    #1;
    total++; if (data !== 8'h00) $display("FAIL rstmid_data got=%h exp=00", data); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", valid); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL rstmid_frame_err got=%b exp=0", frame_err); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rstmid_overrun got=%b exp=0", overrun); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
    rx_pin = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (80) tick();
    total++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_aborted got=%b%b exp=00", valid, busy); else passed++;
    send_frame(8'h5A, 1'b1);
    total++; if (data !== 8'h5A) $display("FAIL rstmid_next_data got=%h exp=5a", data); else passed++;
    total++; if (valid !== 1'b1) $display("FAIL rstmid_next_valid got=%b exp=1", valid); else passed++;
    total++; if (rise_cyc < 78 || rise_cyc > 80) $display("FAIL rstmid_next_latency got=%0d exp=79+/-1", rise_cyc); else passed++;
  endtask

  initial begin
    reset      = 1'b0;
    rx_pin     = 1'b1;
    ack        = 1'b0;
    ack_at     = -1;
    cyc        = 0;
    rise_cyc   = -1;
    ferr_cnt   = 0;
    prev_valid = 1'b0;
    busy_seen  = 1'b0;
    m_data     = 8'h00;
    m_valid    = 1'b0;
    m_overrun  = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_overrun();
    test_ack_in_delivery();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 1000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 125, meaning serial bit rate in bit/s.
REQ-003 SHALL derive CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE, which must be an integer >= 4; elaboration SHALL fail otherwise.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_pin  input  1  serial line, asynchronous to clk, idle high, 8N1, LSB first.
REQ-007 SHALL have port data  output  8  last accepted byte.
REQ-008 SHALL have port valid  output  1  data holds an unacknowledged byte.
REQ-009 SHALL have port ack  input  1  consumer accepts data when high with valid.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky, byte lost while valid held.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL pass rx_pin through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH, with a bit-timing counter and a 3-bit bit index.
REQ-015 IDLE: rx_s==0 -> START with counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles, sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE silently (glitch rejection, no flags).
REQ-017 DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first; after the 8th sample -> STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample rx_s; 1 -> deliver byte, -> IDLE; 0 -> frame_err=1 for exactly one cycle, byte discarded, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_s==1, then -> IDLE; no start detection while line held low (break).
REQ-020 Delivery when valid==0, or when valid==1 and ack==1 in the same cycle: data<=new byte and valid=1 next cycle; overrun unaffected.
REQ-021 Delivery when valid==1 and ack==0: data and valid unchanged, new byte dropped, overrun<=1.
REQ-022 valid&&ack with no delivery that cycle: valid<=0 and overrun<=0 next cycle; data unchanged.
REQ-023 ack while valid==0 SHALL be ignored.
REQ-024 valid SHALL rise one cycle after the stop-bit sample, i.e. 9.5*CLKS_PER_BIT+3 cycles (+/-1) after the rx_pin falling edge.
REQ-025 busy SHALL be combinational from state (state != IDLE).

Reset
REQ-026 While reset==0, regardless of clk: state=IDLE, counters=0, shift register=0, data=8'h00, valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no delivery; after release the first falling edge on rx_s is treated as a new start bit.

Verification (CLOCK_RATE=1000, BAUD_RATE=125, CLKS_PER_BIT=8)
REQ-028 Frame 0xA5 with stop=1 -> valid rises 79+/-1 cycles after start edge, data=0xA5, frame_err=0, overrun=0; ack for 1 cycle -> valid=0.
REQ-029 rx_pin low for 2 cycles then high -> valid, frame_err, overrun stay 0; busy returns to 0 within 8 cycles.
REQ-030 Frame 0x3C with stop bit 0, line then held low for 40 cycles -> one-cycle frame_err, valid=0, no frame started until line high; next frame 0x81 -> data=0x81.
REQ-031 Frames 0x11 then 0x22 with no ack -> data=0x11, valid=1, overrun=1 after second stop; ack -> valid=0, overrun=0, data=0x11.
REQ-032 Frames 0x11 then 0x22, ack pulsed exactly in the second delivery cycle -> data=0x22, valid=1, overrun=0.
REQ-033 reset pulsed low asynchronously mid-way through bit 4 of a frame -> all outputs at reset values immediately; subsequent clean 0x5A frame -> data=0x5A, valid=1.
